// File: rtl/sr_pipe_ctrl.sv
// Pipeline sequencer for the schoolRISCV pipe: next-PC register, decode freeze,
// post-redirect flush, debug halt and branch-resolution timeout.
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  S_BOOT     | first cycle after reset; RESET_PC is being fetched
//  S_RUN      | sequential fetch, decode issuing
//  S_WAIT     | branch in decode, waiting for writeback to resolve it
//  S_REDIRECT | fetch redirected to branch target, wrong-path instr flushed
//  S_HALT     | debug halt, PC held
module sr_pipe_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0,
  parameter int          BRANCH_PENALTY = 2,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_d,
  input  logic             br_valid_w,
  input  logic             br_taken_w,
  input  logic [31:0]      pc_branch_w,
  input  logic [31:0]      pc_plus4_f,
  input  logic             halt_req,
  output logic [31:0]      pc_next_o,
  output logic             freeze_o,
  output logic             flush_o,
  output logic             halted_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] taken_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WCW = $clog2(BRANCH_PENALTY) + 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(BRANCH_PENALTY - 1);

  typedef enum logic [2:0] {
    S_BOOT     = 3'd0,
    S_RUN      = 3'd1,
    S_WAIT     = 3'd2,
    S_REDIRECT = 3'd3,
    S_HALT     = 3'd4
  } state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] wcnt, wcnt_nxt;
  logic [31:0]    pc_nxt;
  logic           freeze_nxt;
  logic           flush_nxt;
  logic           halted_nxt;
  logic           timeout_nxt;
  logic           taken_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_BOOT;
      wcnt        <= '0;
      pc_next_o   <= RESET_PC;
      freeze_o    <= 1'b1;
      flush_o     <= 1'b0;
      halted_o    <= 1'b0;
      timeout_o   <= 1'b0;
      taken_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      state     <= state_nxt;
      wcnt      <= wcnt_nxt;
      pc_next_o <= pc_nxt;
      freeze_o  <= freeze_nxt;
      flush_o   <= flush_nxt;
      halted_o  <= halted_nxt;
      timeout_o <= timeout_nxt;
      if (taken_inc)
        taken_cnt_o <= taken_cnt_o + CNT_W'(1);
      if (freeze_o)
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:     state_nxt = S_RUN;
      S_RUN: begin
        if (halt_req)      state_nxt = S_HALT;
        else if (branch_d) state_nxt = S_WAIT;
      end
      // halt_req is deliberately not looked at here; it is honoured after REDIRECT/RUN
      S_WAIT: begin
        if (br_valid_w)        state_nxt = br_taken_w ? S_REDIRECT : S_RUN;
        else if (wcnt == '0)   state_nxt = S_RUN;
      end
      S_REDIRECT: state_nxt = halt_req ? S_HALT : S_RUN;
      S_HALT: begin
        if (!halt_req) state_nxt = S_RUN;
      end
      default:    state_nxt = S_BOOT;
    endcase
  end

  always_comb begin
    pc_nxt      = pc_next_o;
    freeze_nxt  = freeze_o;
    flush_nxt   = 1'b0;
    halted_nxt  = halted_o;
    timeout_nxt = timeout_o;
    wcnt_nxt    = wcnt;
    taken_inc   = 1'b0;
    case (state)
      S_BOOT: freeze_nxt = 1'b0;
      S_RUN: begin
        if (halt_req) begin
          freeze_nxt = 1'b1;
          halted_nxt = 1'b1;
        end else if (branch_d) begin
          freeze_nxt = 1'b1;
          wcnt_nxt   = WAIT_LOAD;
        end else begin
          pc_nxt     = pc_plus4_f;
          freeze_nxt = 1'b0;
        end
      end
      S_WAIT: begin
        if (br_valid_w && br_taken_w) begin
          pc_nxt    = pc_branch_w;
          flush_nxt = 1'b1;
          taken_inc = 1'b1;
        end else if (br_valid_w || wcnt == '0) begin
          pc_nxt     = pc_plus4_f;
          freeze_nxt = 1'b0;
          if (!br_valid_w)
            timeout_nxt = 1'b1;
        end else begin
          wcnt_nxt = wcnt - WCW'(1);
        end
      end
      S_REDIRECT: begin
        if (halt_req) begin
          freeze_nxt = 1'b1;
          halted_nxt = 1'b1;
        end else begin
          freeze_nxt = 1'b0;
        end
      end
      S_HALT: begin
        if (!halt_req) begin
          freeze_nxt = 1'b0;
          halted_nxt = 1'b0;
        end
      end
      default: begin
        pc_nxt     = RESET_PC;
        freeze_nxt = 1'b1;
        halted_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sr_pipe_ctrl.sv
// Bench for sr_pipe_ctrl: directed scenarios then randomized traffic, all
// outputs compared every cycle against a cycle-level behavioural model.
module tb_sr_pipe_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          PENALTY  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        branch_d = 1'b0, br_valid_w = 1'b0, br_taken_w = 1'b0, halt_req = 1'b0;
  logic [31:0] pc_branch_w = '0, pc_plus4_f = '0;
  logic [31:0] pc_next_o;
  logic        freeze_o, flush_o, halted_o, timeout_o;
  logic [15:0] taken_cnt_o, stall_cnt_o;

  int errors = 0;
  int checks = 0;

  sr_pipe_ctrl #(.RESET_PC(RESET_PC), .BRANCH_PENALTY(PENALTY), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .branch_d(branch_d), .br_valid_w(br_valid_w),
    .br_taken_w(br_taken_w), .pc_branch_w(pc_branch_w), .pc_plus4_f(pc_plus4_f),
    .halt_req(halt_req), .pc_next_o(pc_next_o), .freeze_o(freeze_o), .flush_o(flush_o),
    .halted_o(halted_o), .timeout_o(timeout_o), .taken_cnt_o(taken_cnt_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  // behavioural model
  typedef enum {M_BOOT, M_RUN, M_WAIT, M_REDIR, M_HALT} mode_t;
  mode_t       m;
  logic [31:0] e_pc;
  logic        e_freeze, e_flush, e_halted, e_timeout;
  logic [15:0] e_taken, e_stall;
  int          waited;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m = M_BOOT; e_pc = RESET_PC; e_freeze = 1'b1; e_flush = 1'b0; e_halted = 1'b0;
    e_timeout = 1'b0; e_taken = '0; e_stall = '0; waited = 0;
  endtask

  task automatic model_step(input logic h, input logic b, input logic v, input logic t,
                            input logic [31:0] tgt, input logic [31:0] p4);
    if (e_freeze) e_stall = e_stall + 16'd1;
    e_flush = 1'b0;
    case (m)
      M_BOOT: begin m = M_RUN; e_freeze = 1'b0; end
      M_RUN:
        if (h) begin m = M_HALT; e_freeze = 1'b1; e_halted = 1'b1; end
        else if (b) begin m = M_WAIT; e_freeze = 1'b1; waited = 0; end
        else begin e_pc = p4; e_freeze = 1'b0; end
      M_WAIT:
        if (v && t) begin
          m = M_REDIR; e_pc = tgt; e_flush = 1'b1; e_taken = e_taken + 16'd1;
        end else if (v) begin
          m = M_RUN; e_pc = p4; e_freeze = 1'b0;
        end else if (waited + 1 >= PENALTY) begin
          m = M_RUN; e_pc = p4; e_freeze = 1'b0; e_timeout = 1'b1;
        end else begin
          waited++;
        end
      M_REDIR:
        if (h) begin m = M_HALT; e_freeze = 1'b1; e_halted = 1'b1; end
        else begin m = M_RUN; e_freeze = 1'b0; end
      M_HALT:
        if (!h) begin m = M_RUN; e_freeze = 1'b0; e_halted = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    chk("pc_next", pc_next_o, e_pc);
    chk("freeze", 32'(freeze_o), 32'(e_freeze));
    chk("flush", 32'(flush_o), 32'(e_flush));
    chk("halted", 32'(halted_o), 32'(e_halted));
    chk("timeout", 32'(timeout_o), 32'(e_timeout));
    chk("taken_cnt", 32'(taken_cnt_o), 32'(e_taken));
    chk("stall_cnt", 32'(stall_cnt_o), 32'(e_stall));
    chk("flush_and_halted", 32'(flush_o & halted_o), 32'h0);
  endtask

  task automatic step(input logic h, input logic b, input logic v, input logic t,
                      input logic [31:0] tgt, input logic [31:0] p4);
    halt_req = h; branch_d = b; br_valid_w = v; br_taken_w = t;
    pc_branch_w = tgt; pc_plus4_f = p4;
    @(posedge clk);
    model_step(h, b, v, t, tgt, p4);
    #1 compare_all();
  endtask

  // async reset asserted between edges, held across one edge, released on negedge
  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all();
    @(posedge clk);
    #1 compare_all();
    @(negedge clk);
    rst = 1'b0;
    #1 compare_all();
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, e_pc + 32'd4);
  endtask

  initial begin
    logic        h, b, v, t;
    model_reset();
    #1 do_reset();

    // boot and sequential fetch
    seq(1); chk("boot_pc", pc_next_o, 32'h0);
    seq(1); chk("seq_pc4", pc_next_o, 32'h4);
    seq(1); chk("seq_pc8", pc_next_o, 32'h8);

    // taken branch resolving on first WAIT cycle
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, e_pc + 32'd4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, e_pc + 32'd4);
    chk("taken_pc", pc_next_o, 32'h40);
    chk("taken_flush", 32'(flush_o), 32'h1);
    chk("taken_cnt1", 32'(taken_cnt_o), 32'h1);
    seq(2);

    // not-taken resolving on the last allowed cycle
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, e_pc + 32'd4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, e_pc + 32'd4);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h100);
    chk("nt_pc", pc_next_o, 32'h100);
    chk("nt_timeout", 32'(timeout_o), 32'h0);
    seq(1);

    // never resolved -> timeout, sticky
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, e_pc + 32'd4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, e_pc + 32'd4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h200);
    chk("to_pc", pc_next_o, 32'h200);
    chk("to_set", 32'(timeout_o), 32'h1);
    seq(3);
    chk("to_sticky", 32'(timeout_o), 32'h1);

    // halt during WAIT is deferred until after the redirect
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, e_pc + 32'd4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, e_pc + 32'd4);
    chk("halt_deferred", 32'(halted_o), 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, e_pc + 32'd4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h999);
    chk("halt_entered", 32'(halted_o), 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h999);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h999);
    chk("halt_pc_held", pc_next_o, 32'h300);
    chk("halt_left", 32'(halted_o), 32'h0);

    // reset in the middle of WAIT
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, e_pc + 32'd4);
    do_reset();
    chk("rst_pc", pc_next_o, RESET_PC);
    chk("rst_taken", 32'(taken_cnt_o), 32'h0);
    seq(2);

    // randomized traffic
    h = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 9) == 0) h = ~h;
        b = ($urandom_range(0, 9) < 3);
        v = ($urandom_range(0, 9) < 4);
        t = $urandom_range(0, 1) == 1;
        step(h, b, v, t, $urandom, $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
